// File: rtl/nn_data_buffer_if.sv
// Push/pop/status bundle between the AHB front end, the data buffer and the
// compute core.
//   master : push stream (wr_en_push, is_weight, write_data), clear, pops;
//            observes heads, valids, counts, status and error flags.
//   slave  : the buffer itself; the mirror image of master.
interface nn_data_buffer_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en_push;
  logic             is_weight;
  logic [WIDTH-1:0] write_data;
  logic             clear;
  logic             pop_weight;
  logic             pop_input;

  logic [WIDTH-1:0] weight_data;
  logic             weight_valid;
  logic [WIDTH-1:0] input_data;
  logic             input_valid;
  logic [CW-1:0]    weight_count;
  logic [CW-1:0]    input_count;
  logic             weights_loaded;
  logic             input_full;
  logic [3:0]       err_flags;

  modport master (
    output wr_en_push, is_weight, write_data, clear, pop_weight, pop_input,
    input  weight_data, weight_valid, input_data, input_valid,
           weight_count, input_count, weights_loaded, input_full, err_flags
  );

  modport slave (
    input  wr_en_push, is_weight, write_data, clear, pop_weight, pop_input,
    output weight_data, weight_valid, input_data, input_valid,
           weight_count, input_count, weights_loaded, input_full, err_flags
  );
endinterface

// File: rtl/nn_data_buffer.sv
// Dual-FIFO staging buffer: routes the push stream into a weight FIFO or an
// input FIFO and lets the compute core drain each one through a show-ahead
// valid/pop interface.
//   clk, n_rst : clock (rising edge), asynchronous active-low reset
//   bus        : nn_data_buffer_if.slave (push stream, clear, pops, heads,
//                counts, weights_loaded, input_full, sticky err_flags)

// One show-ahead FIFO with sticky overrun/underrun flags.
//   clear_i          : synchronous flush of pointers, count and flags
//   push_i / data_i  : write request and word
//   pop_i            : consume head
//   head_o, count_o  : head word (0 when empty), occupancy
//   ovr_o, udr_o     : sticky overrun / underrun
module nn_data_buffer_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovr_o,
  output logic                       udr_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovr_q, ovr_d;
  logic             udr_q, udr_d;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop_i && !empty && !clear_i;
  assign do_push = push_i && (!full || pop_i) && !clear_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovr_d   = ovr_q;
    udr_d   = udr_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovr_d   = 1'b0;
      udr_d   = 1'b0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);
      if (push_i && full && !pop_i) ovr_d = 1'b1;
      if (pop_i && empty)           udr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      udr_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
      udr_q   <= udr_d;
    end
  end

  // Storage has no reset; the count gating on head_o hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign head_o  = empty ? '0 : mem_q[rptr_q];
  assign count_o = count_q;
  assign ovr_o   = ovr_q;
  assign udr_o   = udr_q;
endmodule

module nn_data_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  nn_data_buffer_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic w_ovr, w_udr, i_ovr, i_udr;
  logic [CW-1:0] w_count, i_count;

  nn_data_buffer_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_weight_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear_i (bus.clear),
    .push_i  (bus.wr_en_push && bus.is_weight),
    .pop_i   (bus.pop_weight),
    .data_i  (bus.write_data),
    .head_o  (bus.weight_data),
    .count_o (w_count),
    .ovr_o   (w_ovr),
    .udr_o   (w_udr)
  );

  nn_data_buffer_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_input_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear_i (bus.clear),
    .push_i  (bus.wr_en_push && !bus.is_weight),
    .pop_i   (bus.pop_input),
    .data_i  (bus.write_data),
    .head_o  (bus.input_data),
    .count_o (i_count),
    .ovr_o   (i_ovr),
    .udr_o   (i_udr)
  );

  assign bus.weight_count   = w_count;
  assign bus.input_count    = i_count;
  assign bus.weight_valid   = (w_count != '0);
  assign bus.input_valid    = (i_count != '0);
  assign bus.weights_loaded = (w_count == CW'(DEPTH));
  assign bus.input_full     = (i_count == CW'(DEPTH));
  assign bus.err_flags      = {i_udr, i_ovr, w_udr, w_ovr};
endmodule

// File: tb/tb_nn_data_buffer.sv
module tb_nn_data_buffer;
  localparam int DEPTH = 8;
  localparam int WIDTH = 64;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nn_data_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  nn_data_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // Reference model: two plain queues plus four sticky bits.
  logic [WIDTH-1:0] wq[$];
  logic [WIDTH-1:0] iq[$];
  bit m_wo, m_wu, m_io, m_iu;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst || bus.clear) begin
      wq.delete(); iq.delete();
      {m_iu, m_io, m_wu, m_wo} = 4'b0;
    end else begin
      if (bus.pop_weight) begin
        if (wq.size() == 0) m_wu = 1;
      end
      if (bus.wr_en_push && bus.is_weight) begin
        if (wq.size() == DEPTH && !bus.pop_weight) m_wo = 1;
        else begin
          if (bus.pop_weight && wq.size() != 0) void'(wq.pop_front());
          wq.push_back(bus.write_data);
        end
      end else if (bus.pop_weight && wq.size() != 0) void'(wq.pop_front());

      if (bus.pop_input) begin
        if (iq.size() == 0) m_iu = 1;
      end
      if (bus.wr_en_push && !bus.is_weight) begin
        if (iq.size() == DEPTH && !bus.pop_input) m_io = 1;
        else begin
          if (bus.pop_input && iq.size() != 0) void'(iq.pop_front());
          iq.push_back(bus.write_data);
        end
      end else if (bus.pop_input && iq.size() != 0) void'(iq.pop_front());
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("weight_data", bus.weight_data, (wq.size() != 0) ? wq[0] : '0);
    chk("input_data", bus.input_data, (iq.size() != 0) ? iq[0] : '0);
    chk("weight_valid", 64'(bus.weight_valid), 64'(wq.size() != 0));
    chk("input_valid", 64'(bus.input_valid), 64'(iq.size() != 0));
    chk("weight_count", 64'(bus.weight_count), 64'(wq.size()));
    chk("input_count", 64'(bus.input_count), 64'(iq.size()));
    chk("weights_loaded", 64'(bus.weights_loaded), 64'(wq.size() == DEPTH));
    chk("input_full", 64'(bus.input_full), 64'(iq.size() == DEPTH));
    chk("err_flags", 64'(bus.err_flags), 64'({m_iu, m_io, m_wu, m_wo}));
  end

  task automatic idle();
    bus.wr_en_push = 0; bus.is_weight = 0; bus.write_data = '0;
    bus.pop_weight = 0; bus.pop_input = 0; bus.clear = 0;
  endtask

  // Drive one cycle of inputs, let the edge happen, return 1 time unit later.
  task automatic cyc(input bit push, input bit isw, input logic [WIDTH-1:0] d,
                     input bit pw, input bit pi, input bit clr);
    bus.wr_en_push = push; bus.is_weight = isw; bus.write_data = d;
    bus.pop_weight = pw; bus.pop_input = pi; bus.clear = clr;
    @(posedge clk);
    #1 idle();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_wcount"}, 64'(bus.weight_count), 64'd0);
    chk({tag, "_icount"}, 64'(bus.input_count), 64'd0);
    chk({tag, "_wvalid"}, 64'(bus.weight_valid), 64'd0);
    chk({tag, "_ivalid"}, 64'(bus.input_valid), 64'd0);
    chk({tag, "_wdata"}, bus.weight_data, 64'd0);
    chk({tag, "_idata"}, bus.input_data, 64'd0);
    chk({tag, "_loaded"}, 64'(bus.weights_loaded), 64'd0);
    chk({tag, "_full"}, 64'(bus.input_full), 64'd0);
    chk({tag, "_err"}, 64'(bus.err_flags), 64'd0);
  endtask

  initial begin
    idle();
    #2 chk_reset_values("rst");
    #10 n_rst = 1'b1;

    // 8 weights in, 8 pops out
    for (int i = 1; i <= 8; i++) cyc(1, 1, 64'(i), 0, 0, 0);
    chk("lit_loaded", 64'(bus.weights_loaded), 64'd1);
    chk("lit_wcount8", 64'(bus.weight_count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("lit_whead", bus.weight_data, 64'(i + 1));
      chk("lit_wcount_step", 64'(bus.weight_count), 64'(8 - i));
      cyc(0, 0, '0, 1, 0, 0);
    end
    chk("lit_wcount0", 64'(bus.weight_count), 64'd0);
    chk("lit_err_clean", 64'(bus.err_flags), 64'd0);

    // interleaved routing
    cyc(1, 1, 64'hA, 0, 0, 0);
    cyc(1, 0, 64'hB, 0, 0, 0);
    cyc(1, 1, 64'hC, 0, 0, 0);
    cyc(1, 0, 64'hD, 0, 0, 0);
    chk("lit_il_wcount", 64'(bus.weight_count), 64'd2);
    chk("lit_il_icount", 64'(bus.input_count), 64'd2);
    chk("lit_il_whead", bus.weight_data, 64'hA);
    chk("lit_il_ihead", bus.input_data, 64'hB);
    cyc(0, 0, '0, 1, 1, 0);
    chk("lit_il_whead2", bus.weight_data, 64'hC);
    chk("lit_il_ihead2", bus.input_data, 64'hD);
    cyc(0, 0, '0, 1, 1, 0);

    // input overrun, then push+pop on full
    for (int i = 0; i < 8; i++) cyc(1, 0, 64'(8'h10 + i), 0, 0, 0);
    cyc(1, 0, 64'hFF, 0, 0, 0);
    chk("lit_ovr_count", 64'(bus.input_count), 64'd8);
    chk("lit_ovr_full", 64'(bus.input_full), 64'd1);
    chk("lit_ovr_err", 64'(bus.err_flags), 64'b0100);
    cyc(1, 0, 64'h77, 0, 1, 0);
    chk("lit_pp_count", 64'(bus.input_count), 64'd8);
    chk("lit_pp_err", 64'(bus.err_flags), 64'b0100);
    chk("lit_pp_head", bus.input_data, 64'h11);

    // weight underrun, then push+pop on empty
    cyc(0, 0, '0, 0, 0, 1);
    chk("lit_clr_err", 64'(bus.err_flags), 64'd0);
    chk("lit_clr_icount", 64'(bus.input_count), 64'd0);
    cyc(0, 0, '0, 1, 0, 0);
    chk("lit_udr_err", 64'(bus.err_flags), 64'b0010);
    chk("lit_udr_count", 64'(bus.weight_count), 64'd0);
    cyc(1, 1, 64'h55, 1, 0, 0);
    chk("lit_epp_count", 64'(bus.weight_count), 64'd1);
    chk("lit_epp_err", 64'(bus.err_flags), 64'b0010);
    chk("lit_epp_head", bus.weight_data, 64'h55);

    // clear beats a same-cycle push
    cyc(0, 0, '0, 0, 1, 0);
    chk("lit_iudr_err", 64'(bus.err_flags), 64'b1010);
    cyc(1, 1, 64'h56, 0, 0, 0);
    cyc(1, 1, 64'h57, 0, 0, 0);
    for (int i = 1; i <= 3; i++) cyc(1, 0, 64'(i), 0, 0, 0);
    chk("lit_pre_wcount", 64'(bus.weight_count), 64'd3);
    chk("lit_pre_icount", 64'(bus.input_count), 64'd3);
    cyc(1, 1, 64'h99, 0, 0, 1);
    chk_reset_values("clr");

    // async reset mid-burst
    for (int i = 0; i < 5; i++) cyc(1, (i % 2) == 0, 64'(8'h40 + i), 0, 0, 0);
    chk("lit_burst_wcount", 64'(bus.weight_count), 64'd3);
    chk("lit_burst_icount", 64'(bus.input_count), 64'd2);
    cyc(0, 0, '0, 1, 1, 0);
    cyc(0, 0, '0, 0, 1, 1);
    cyc(0, 0, '0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, (i % 2) == 0, 64'(8'h40 + i), 0, 0, 0);
    #2 n_rst = 1'b0;
    #1 chk_reset_values("arst");
    @(negedge clk);
    #1 n_rst = 1'b1;
    cyc(0, 0, '0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nn_data_buffer.md
# nn_data_buffer

Dual-FIFO staging buffer between the AHB register front end and the compute core. It accepts the single-cycle push stream (`wr_en_push`, `is_weight`, `write_data`) and routes each 64-bit word into a weight FIFO or an input FIFO. The core drains each FIFO independently through a show-ahead valid/pop interface. Occupancy, full/loaded status and sticky over/underrun flags are exported for the status and error registers.

## Interface
- `DEPTH`, default 8: entries per FIFO; must be a power of two, ≥2.
- `WIDTH`, default 64: data word width.
- `clk`  in  1  clock, rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `wr_en_push`  in  1  push strobe; one word per cycle while high.
- `is_weight`  in  1  routing tag sampled with `wr_en_push`: 1 = weight FIFO, 0 = input FIFO.
- `write_data`  in  WIDTH  push data.
- `clear`  in  1  synchronous flush of both FIFOs and all error flags.
- `pop_weight`  in  1  consume the head of the weight FIFO.
- `pop_input`  in  1  consume the head of the input FIFO.
- `weight_data`  out  WIDTH  weight FIFO head; 0 when empty.
- `weight_valid`  out  1  weight FIFO non-empty.
- `input_data`  out  WIDTH  input FIFO head; 0 when empty.
- `input_valid`  out  1  input FIFO non-empty.
- `weight_count`  out  $clog2(DEPTH)+1  weight FIFO occupancy.
- `input_count`  out  $clog2(DEPTH)+1  input FIFO occupancy.
- `weights_loaded`  out  1  `weight_count == DEPTH`.
- `input_full`  out  1  `input_count == DEPTH`.
- `err_flags`  out  4  sticky flags {input_underrun, input_overrun, weight_underrun, weight_overrun}.

## Operation
- Two identical FIFO instances: storage array, read and write pointers (`$clog2(DEPTH)` bits each, wrapping naturally from DEPTH-1 to 0), and a count register.
- Push routing: when `wr_en_push`=1, the word goes to the weight FIFO if `is_weight`=1, otherwise to the input FIFO. The other FIFO is untouched.
- Push to a full FIFO with no same-cycle pop on that FIFO: the word is dropped, pointers and count are unchanged, and that FIFO's overrun flag sets.
- Pop of an empty FIFO: ignored and that FIFO's underrun flag sets. This includes an empty FIFO receiving a push and a pop in the same cycle: the push is accepted (count becomes 1) and the underrun flag sets.
- Push and pop of a non-empty FIFO in the same cycle: both take effect and the count is unchanged. This holds when the FIFO is full, so no overrun is flagged.
- Count update is +1 on push only, -1 on pop only, and 0 on both or neither. Count never exceeds DEPTH and never goes below 0.
- Head outputs are combinational from `mem[rptr]`, gated to 0 when count is 0. The storage array is not reset.
- `clear` takes priority over push and pop in the same cycle. It zeroes pointers, counts and `err_flags`, and the same-cycle push is discarded.
- Error flags stay set until `clear` or reset.

## Timing
- Reset values: all counts 0, all `*_valid` 0, all data outputs 0, `weights_loaded` 0, `input_full` 0, `err_flags` 4'b0000.
- Push latency is 1: a word pushed at edge N is visible on the head output, with valid high, from edge N onward.
- A pop at edge N presents the next entry, or 0 with valid low, immediately after edge N.
- Status outputs (`weights_loaded`, `input_full`, counts) change on the same edge as the count register; there is no additional delay.
- Error flags assert on the edge following the offending cycle's inputs.
- Asserting `n_rst` mid-burst immediately empties both FIFOs and clears all flags; words in flight are lost.

## Test plan
- Push 8 weights 0x01..0x08 (`is_weight`=1), then pop 8 times -> `weights_loaded`=1 after the 8th push; heads read 0x01..0x08 in order; `weight_count` steps 8→0; `err_flags`=0.
- Interleaved pushes with `is_weight` 1,0,1,0 carrying 0xA,0xB,0xC,0xD -> weight FIFO holds {0xA,0xC}, input FIFO holds {0xB,0xD}; both counts 2.
- Fill the input FIFO to 8, push 0xFF -> word dropped, `input_count`=8, `err_flags`=4'b0100. Then push and pop together -> count stays 8, no new flag.
- Pop an empty weight FIFO -> `err_flags[1]`=1, count stays 0. Then push and pop together on the empty FIFO -> count=1 and the underrun flag remains set.
- With both FIFOs at count 3 and flags set, assert `clear` together with a push -> both counts 0, `err_flags`=0, push discarded.
- Assert `n_rst` low after 5 pushes -> all outputs return to their reset values asynchronously, before the next edge.
